opcode_byte_queue: RTL and testbench

//  Byte queue between instruction fetch and the control-store opcode select.

---
 rtl/opcode_byte_queue.sv | 240 ++++++++++++++++++++++++
 tb/tb_opcode_byte_queue.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opcode_byte_queue.sv
// opcode_byte_queue: byte queue between instruction fetch and opcode select.
// Fetch lines are written into a circular byte buffer; legacy prefixes at the
// head are stripped one per cycle into flags, then B1..B3 and an 8-byte window
// are presented until decode pops the instruction by length.
// Optional feature macro: OBQ_PREFIX_FAULT_EN (prefix-count fault, pfx_fault port).
module opcode_byte_queue #(
  parameter int unsigned LINE_BYTES  = 16,
  parameter int unsigned DEPTH_BYTES = 32,
  parameter int unsigned WIN_BYTES   = 8
`ifdef OBQ_PREFIX_FAULT_EN
  ,
  parameter int unsigned MAX_PREFIX  = 4
`endif
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            fl_valid,
  output logic                            fl_ready,
  input  logic [LINE_BYTES*8-1:0]         fl_line,
  output logic                            oq_valid,
  output logic [7:0]                      B1,
  output logic [7:0]                      B2,
  output logic [7:0]                      B3,
  output logic [WIN_BYTES*8-1:0]          oq_win,
  output logic                            pfx_opsize,
  output logic                            pfx_lock,
  output logic                            pfx_rep,
  output logic                            pfx_repne,
  output logic                            pfx_seg_ov,
  output logic [2:0]                      pfx_seg,
  output logic [2:0]                      pfx_cnt,
  input  logic                            dec_take,
  input  logic [3:0]                      dec_len,
  output logic [$clog2(DEPTH_BYTES):0]    occupancy
`ifdef OBQ_PREFIX_FAULT_EN
  ,
  output logic                            pfx_fault
`endif
);

  localparam int unsigned PW = $clog2(DEPTH_BYTES);
  localparam int unsigned OW = PW + 1;

  typedef enum logic {
    SCAN,
    PRESENT
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [7:0]             r_mem [DEPTH_BYTES];
  logic [PW-1:0]          r_rd_ptr;
  logic [PW-1:0]          r_wr_ptr;
  logic [OW-1:0]          r_occ;

  logic                   r_opsize;
  logic                   r_lock;
  logic                   r_rep;
  logic                   r_repne;
  logic                   r_seg_ov;
  logic [2:0]             r_seg;
  logic [2:0]             r_cnt;
`ifdef OBQ_PREFIX_FAULT_EN
  logic                   r_fault;
  logic                   w_fault_set;
`endif

  logic [7:0]             w_head;
  logic                   w_is_pfx;
  logic                   w_push;
  logic                   w_pfx_pop;
  logic                   w_clr_flags;
  logic [OW-1:0]          w_pop_n;
  logic [3:0]             w_take_len;
  logic [OW-1:0]          w_free;
  logic [WIN_BYTES*8-1:0] w_win;

  // Head byte classification and push acceptance (pre-cycle occupancy)
  always_comb begin
    w_head = r_mem[r_rd_ptr];
    case (w_head)
      8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65,
      8'h66, 8'hF0, 8'hF2, 8'hF3: w_is_pfx = 1'b1;
      default:                    w_is_pfx = 1'b0;
    endcase
    w_free   = OW'(DEPTH_BYTES) - r_occ;
    fl_ready = !flush && (w_free >= OW'(LINE_BYTES));
    w_push   = fl_valid && fl_ready;
    if (dec_len == 4'd0) begin
      w_take_len = 4'd1;
    end else if (dec_len > 4'(WIN_BYTES)) begin
      w_take_len = 4'(WIN_BYTES);
    end else begin
      w_take_len = dec_len;
    end
  end

  // Next-state and pop control
  always_comb begin
    w_state_nxt = r_state;
    w_pfx_pop   = 1'b0;
    w_clr_flags = 1'b0;
    w_pop_n     = '0;
`ifdef OBQ_PREFIX_FAULT_EN
    w_fault_set = 1'b0;
`endif
    case (r_state)
      SCAN: begin
        if ((r_occ != '0) && w_is_pfx) begin
`ifdef OBQ_PREFIX_FAULT_EN
          if (r_cnt == 3'(MAX_PREFIX)) begin
            w_fault_set = 1'b1;
          end else begin
            w_pfx_pop = 1'b1;
          end
`else
          w_pfx_pop = 1'b1;
`endif
        end else if (!w_is_pfx && (r_occ >= OW'(WIN_BYTES))) begin
          w_state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (dec_take) begin
          w_pop_n     = OW'(w_take_len);
          w_clr_flags = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      default: w_state_nxt = SCAN;
    endcase
    if (w_pfx_pop) begin
      w_pop_n = OW'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= SCAN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Buffer write; accepted lines only, so flush drops the line
  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int unsigned i = 0; i < LINE_BYTES; i++) begin
        r_mem[r_wr_ptr + PW'(i)] <= fl_line[i*8 +: 8];
      end
    end
  end

  // Pointers and occupancy; push and pop apply together in one cycle
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + w_pop_n[PW-1:0];
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(LINE_BYTES);
      end
      r_occ <= r_occ + (w_push ? OW'(LINE_BYTES) : '0) - w_pop_n;
    end
  end

  // Prefix flags: set while stripping, cleared on take, flush or reset
  always_ff @(posedge clk) begin
    if (rst || flush || w_clr_flags) begin
      r_opsize <= 1'b0;
      r_lock   <= 1'b0;
      r_rep    <= 1'b0;
      r_repne  <= 1'b0;
      r_seg_ov <= 1'b0;
      r_seg    <= '0;
      r_cnt    <= '0;
    end else if (w_pfx_pop) begin
      if (r_cnt != 3'd7) begin
        r_cnt <= r_cnt + 3'd1;
      end
      case (w_head)
        8'h66: r_opsize <= 1'b1;
        8'hF0: r_lock   <= 1'b1;
        8'hF2: begin r_repne <= 1'b1; r_rep   <= 1'b0; end
        8'hF3: begin r_rep   <= 1'b1; r_repne <= 1'b0; end
        8'h26: begin r_seg_ov <= 1'b1; r_seg <= 3'd0; end
        8'h2E: begin r_seg_ov <= 1'b1; r_seg <= 3'd1; end
        8'h36: begin r_seg_ov <= 1'b1; r_seg <= 3'd2; end
        8'h3E: begin r_seg_ov <= 1'b1; r_seg <= 3'd3; end
        8'h64: begin r_seg_ov <= 1'b1; r_seg <= 3'd4; end
        8'h65: begin r_seg_ov <= 1'b1; r_seg <= 3'd5; end
        default: ;
      endcase
    end
  end

`ifdef OBQ_PREFIX_FAULT_EN
  // Sticky prefix-limit fault; the offending byte stays at the head
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_fault <= 1'b0;
    end else if (w_fault_set) begin
      r_fault <= 1'b1;
    end
  end

  assign pfx_fault = r_fault;
`endif

  // Decode window from rd_ptr; pointer arithmetic wraps at the buffer end
  always_comb begin
    w_win = '0;
    for (int unsigned i = 0; i < WIN_BYTES; i++) begin
      w_win[i*8 +: 8] = r_mem[r_rd_ptr + PW'(i)];
    end
  end

  // Outputs are zero outside PRESENT so reset and idle values are defined
  always_comb begin
    oq_valid   = (r_state == PRESENT);
    oq_win     = oq_valid ? w_win : '0;
    B1         = oq_win[7:0];
    B2         = oq_win[15:8];
    B3         = oq_win[23:16];
    pfx_opsize = r_opsize;
    pfx_lock   = r_lock;
    pfx_rep    = r_rep;
    pfx_repne  = r_repne;
    pfx_seg_ov = r_seg_ov;
    pfx_seg    = r_seg;
    pfx_cnt    = r_cnt;
    occupancy  = r_occ;
  end

endmodule

// File: tb/tb_opcode_byte_queue.sv
// tb_opcode_byte_queue: directed scenarios plus randomized traffic, every
// cycle compared against a byte-queue reference model.
// Honours OBQ_PREFIX_FAULT_EN in the same way as the design.
module tb_opcode_byte_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         fl_valid;
  logic         fl_ready;
  logic [127:0] fl_line;
  logic         oq_valid;
  logic [7:0]   B1, B2, B3;
  logic [63:0]  oq_win;
  logic         pfx_opsize, pfx_lock, pfx_rep, pfx_repne, pfx_seg_ov;
  logic [2:0]   pfx_seg, pfx_cnt;
  logic         dec_take;
  logic [3:0]   dec_len;
  logic [5:0]   occupancy;
`ifdef OBQ_PREFIX_FAULT_EN
  logic         pfx_fault;
`endif

  opcode_byte_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fl_valid(fl_valid), .fl_ready(fl_ready), .fl_line(fl_line),
    .oq_valid(oq_valid), .B1(B1), .B2(B2), .B3(B3), .oq_win(oq_win),
    .pfx_opsize(pfx_opsize), .pfx_lock(pfx_lock), .pfx_rep(pfx_rep),
    .pfx_repne(pfx_repne), .pfx_seg_ov(pfx_seg_ov), .pfx_seg(pfx_seg),
    .pfx_cnt(pfx_cnt), .dec_take(dec_take), .dec_len(dec_len),
    .occupancy(occupancy)
`ifdef OBQ_PREFIX_FAULT_EN
    , .pfx_fault(pfx_fault)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the queue contents, a presenting bit and the flags
  logic [7:0] q[$];
  bit         m_pres;
  bit         m_opsize, m_lock, m_rep, m_repne, m_seg_ov, m_fault;
  int         m_seg, m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_pfx(input logic [7:0] b);
    case (b)
      8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65,
      8'h66, 8'hF0, 8'hF2, 8'hF3: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] pfx_at(input int i);
    case (i)
      0: return 8'h26; 1: return 8'h2E; 2: return 8'h36; 3: return 8'h3E;
      4: return 8'h64; 5: return 8'h65; 6: return 8'h66; 7: return 8'hF0;
      8: return 8'hF2; default: return 8'hF3;
    endcase
  endfunction

  task automatic clear_flags();
    m_opsize = 0; m_lock = 0; m_rep = 0; m_repne = 0; m_seg_ov = 0;
    m_seg = 0; m_cnt = 0;
  endtask

  task automatic apply_pfx(input logic [7:0] b);
    case (b)
      8'h66: m_opsize = 1;
      8'hF0: m_lock = 1;
      8'hF2: begin m_repne = 1; m_rep = 0; end
      8'hF3: begin m_rep = 1; m_repne = 0; end
      8'h26: begin m_seg_ov = 1; m_seg = 0; end
      8'h2E: begin m_seg_ov = 1; m_seg = 1; end
      8'h36: begin m_seg_ov = 1; m_seg = 2; end
      8'h3E: begin m_seg_ov = 1; m_seg = 3; end
      8'h64: begin m_seg_ov = 1; m_seg = 4; end
      default: begin m_seg_ov = 1; m_seg = 5; end
    endcase
    if (m_cnt < 7) m_cnt++;
  endtask

  // Advance the model by one clock using the inputs of that cycle
  task automatic model_cycle(input logic fv, input logic [127:0] ln,
                             input logic fls, input logic tk, input logic [3:0] len);
    bit do_push;
    int n;
    if (fls) begin
      q.delete(); m_pres = 0; m_fault = 0; clear_flags();
      return;
    end
    do_push = fv && (q.size() <= 16);
    if (m_pres) begin
      if (tk) begin
        n = (len == 0) ? 1 : ((len > 8) ? 8 : int'(len));
        repeat (n) void'(q.pop_front());
        clear_flags();
        m_pres = 0;
      end
    end else if (q.size() >= 1 && is_pfx(q[0])) begin
`ifdef OBQ_PREFIX_FAULT_EN
      if (m_cnt == 4) m_fault = 1;
      else apply_pfx(q.pop_front());
`else
      apply_pfx(q.pop_front());
`endif
    end else if (q.size() >= 8) begin
      m_pres = 1;
    end
    if (do_push)
      for (int i = 0; i < 16; i++) q.push_back(ln[i*8 +: 8]);
  endtask

  task automatic cmp_all();
    logic [63:0] w;
    w = '0;
    if (m_pres)
      for (int i = 0; i < 8; i++) w[i*8 +: 8] = q[i];
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("oq_valid", 64'(oq_valid), 64'(m_pres));
    chk("oq_win", oq_win, w);
    chk("B1", 64'(B1), 64'(w[7:0]));
    chk("B2", 64'(B2), 64'(w[15:8]));
    chk("B3", 64'(B3), 64'(w[23:16]));
    chk("pfx_opsize", 64'(pfx_opsize), 64'(m_opsize));
    chk("pfx_lock", 64'(pfx_lock), 64'(m_lock));
    chk("pfx_rep", 64'(pfx_rep), 64'(m_rep));
    chk("pfx_repne", 64'(pfx_repne), 64'(m_repne));
    chk("pfx_seg_ov", 64'(pfx_seg_ov), 64'(m_seg_ov));
    chk("pfx_seg", 64'(pfx_seg), 64'(m_seg));
    chk("pfx_cnt", 64'(pfx_cnt), 64'(m_cnt));
`ifdef OBQ_PREFIX_FAULT_EN
    chk("pfx_fault", 64'(pfx_fault), 64'(m_fault));
`endif
  endtask

  // One clock: drive at the negedge, check ready, clock, check outputs
  task automatic step(input logic fv, input logic [127:0] ln, input logic fls,
                      input logic tk, input logic [3:0] len);
    fl_valid = fv; fl_line = ln; flush = fls; dec_take = tk; dec_len = len;
    #1;
    chk("fl_ready", 64'(fl_ready), 64'(!fls && (q.size() <= 16)));
    model_cycle(fv, ln, fls, tk, len);
    @(negedge clk);
    fl_valid = 0; flush = 0; dec_take = 0; dec_len = '0;
    cmp_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic push(input logic [127:0] ln);
    step(1'b1, ln, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic take(input logic [3:0] len);
    step(1'b0, '0, 1'b0, 1'b1, len);
  endtask

  // Bounded wait for the model to reach PRESENT; expiry counts as a failure
  task automatic idle_until_valid();
    int k;
    k = 0;
    while (!m_pres && k < 20) begin
      idle(1);
      k++;
    end
    chk("wait_valid_timeout", 64'(m_pres), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; fl_valid = 0; fl_line = '0; dec_take = 0; dec_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    q.delete(); m_pres = 0; m_fault = 0; clear_flags();
    cmp_all();
  endtask

  function automatic logic [127:0] fill_line(input logic [7:0] b);
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[i*8 +: 8] = b;
    return l;
  endfunction

  function automatic logic [7:0] rnd_byte();
    if ($urandom_range(0, 5) == 0) return pfx_at($urandom_range(0, 9));
    return 8'($urandom);
  endfunction

  logic [127:0] ln;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    do_reset();
    chk("rst_fl_ready", 64'(fl_ready), 64'd1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_oq_win", oq_win, 64'd0);

    // T1: one 66 prefix, then B8 34 12
    ln = fill_line(8'h90);
    ln[7:0] = 8'h66; ln[15:8] = 8'hB8; ln[23:16] = 8'h34; ln[31:24] = 8'h12;
    push(ln);
    idle(1);
    chk("t1_opsize", 64'(pfx_opsize), 64'd1);
    chk("t1_cnt", 64'(pfx_cnt), 64'd1);
    idle(1);
    chk("t1_valid", 64'(oq_valid), 64'd1);
    chk("t1_B1", 64'(B1), 64'hB8);
    chk("t1_B2", 64'(B2), 64'h34);
    chk("t1_B3", 64'(B3), 64'h12);

    // T2: take 3
    take(4'd3);
    chk("t2_opsize_clr", 64'(pfx_opsize), 64'd0);
    idle(1);
    chk("t2_B1", 64'(B1), 64'h90);
    chk("t2_occ", 64'(occupancy), 64'd12);
    chk("t2_valid", 64'(oq_valid), 64'd1);

    // T3: fill to capacity, refused third line, drain
    do_reset();
    push(fill_line(8'h90));
    push(fill_line(8'h91));
    chk("t3_occ_full", 64'(occupancy), 64'd32);
    push(fill_line(8'h92));
    chk("t3_occ_held", 64'(occupancy), 64'd32);
    idle_until_valid();
    take(4'd8);
    #1 chk("t3_ready_24", 64'(fl_ready), 64'd0);
    idle_until_valid();
    take(4'd8);
    #1 chk("t3_ready_16", 64'(fl_ready), 64'd1);

    // T4: wrap the window across the buffer end (rd_ptr 28)
    do_reset();
    push(fill_line(8'h90));
    idle_until_valid();
    take(4'd8);
    idle_until_valid();
    take(4'd8);
    ln = fill_line(8'h90);
    ln[103:96] = 8'h66; ln[111:104] = 8'hF0; ln[119:112] = 8'h0F; ln[127:120] = 8'hAF;
    push(ln);
    ln = fill_line(8'h90);
    ln[7:0] = 8'hC3;
    push(ln);
    idle_until_valid();
    take(4'd8);
    idle_until_valid();
    take(4'd4);
    idle_until_valid();
    chk("t4_B1", 64'(B1), 64'h0F);
    chk("t4_B2", 64'(B2), 64'hAF);
    chk("t4_B3", 64'(B3), 64'hC3);

    // T5: flush with a line and a take in PRESENT
    step(1'b1, fill_line(8'h55), 1'b1, 1'b1, 4'd2);
    chk("t5_occ", 64'(occupancy), 64'd0);
    chk("t5_valid", 64'(oq_valid), 64'd0);
    chk("t5_lock", 64'(pfx_lock), 64'd0);
    idle(2);

    // T6: five prefixes ahead of opcode 01
    do_reset();
    ln = fill_line(8'h90);
    ln[7:0] = 8'hF0; ln[15:8] = 8'hF3; ln[23:16] = 8'h66;
    ln[31:24] = 8'h2E; ln[39:32] = 8'h26; ln[47:40] = 8'h01;
    push(ln);
    idle(7);
`ifdef OBQ_PREFIX_FAULT_EN
    chk("t6_fault", 64'(pfx_fault), 64'd1);
    chk("t6_valid", 64'(oq_valid), 64'd0);
    chk("t6_cnt", 64'(pfx_cnt), 64'd4);
`else
    chk("t6_cnt", 64'(pfx_cnt), 64'd5);
    chk("t6_seg", 64'(pfx_seg), 64'd0);
    chk("t6_rep", 64'(pfx_rep), 64'd1);
    chk("t6_lock", 64'(pfx_lock), 64'd1);
    chk("t6_B1", 64'(B1), 64'h01);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 16; i++) ln[i*8 +: 8] = rnd_byte();
      step($urandom_range(0, 1) == 1, ln, $urandom_range(0, 49) == 0,
           $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
